systolic_result_drain: RTL and testbench

SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

---
 rtl/systolic_result_drain.sv | 68 ++++++
 tb/tb_systolic_result_drain.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: captures an M x M result tile on done and streams it out over valid/ready.
// Optional DRAIN_COL_MAJOR_EN selects column-major order (default row-major).
module systolic_result_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int M = 3,
  localparam int RW = (M > 1) ? $clog2(M) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] result_in [0:M-1][0:M-1],
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [RW-1:0]         m_row,
  output logic [RW-1:0]         m_col,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  clr_overrun
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;
  localparam logic [RW-1:0] LAST_IDX = RW'(M - 1);
  logic [0:0] state;
  logic [RW-1:0] row, col, row_n, col_n;
  logic [DATA_WIDTH-1:0] tile [0:M-1][0:M-1];
  logic at_last, xfer, fin, load, drop;
  assign busy = state == STREAM;
  assign m_valid = busy;
  assign at_last = row == LAST_IDX && col == LAST_IDX;
  assign xfer = busy && m_ready;
  assign fin = xfer && at_last;
  // a tile is only accepted when the buffer is free by the end of this edge
  assign load = done && (!busy || fin);
  assign drop = done && busy && !fin;
`ifdef DRAIN_COL_MAJOR_EN
  always_comb begin
    row_n = (row == LAST_IDX) ? '0 : row + 1'b1;
    col_n = (row == LAST_IDX) ? col + 1'b1 : col;
  end
`else
  always_comb begin
    col_n = (col == LAST_IDX) ? '0 : col + 1'b1;
    row_n = (col == LAST_IDX) ? row + 1'b1 : row;
  end
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      overrun <= 1'b0;
    end else begin
      state <= load ? STREAM : fin ? IDLE : state;
      row <= (load || fin) ? '0 : xfer ? row_n : row;
      col <= (load || fin) ? '0 : xfer ? col_n : col;
      overrun <= drop | (overrun & ~clr_overrun);
    end
  end
  always_ff @(posedge clk) begin
    if (load) tile <= result_in;
  end
  assign m_data = busy ? tile[row][col] : '0;
  assign m_row = busy ? row : '0;
  assign m_col = busy ? col : '0;
  assign m_last = busy && at_last;
endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain: randomized scoreboard bench; expected beats are queued per accepted tile.
module tb_systolic_result_drain;
  localparam int DW = 32;
  localparam int M = 3;
  typedef struct {
    logic [DW-1:0] data;
    int row;
    int col;
    bit last;
  } beat_t;
  logic clk = 0;
  logic reset_n = 0;
  logic done = 0;
  logic [DW-1:0] result_in [0:M-1][0:M-1];
  logic m_valid, m_ready, m_last, busy, overrun, clr_overrun;
  logic [DW-1:0] m_data;
  logic [1:0] m_row, m_col;
  beat_t q[$];
  int pending = 0;
  bit ov = 0;
  int compared = 0;
  int mismatched = 0;
  systolic_result_drain #(.DATA_WIDTH(DW), .M(M)) dut (
    .clk(clk), .reset_n(reset_n), .done(done), .result_in(result_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .m_row(m_row), .m_col(m_col), .busy(busy), .overrun(overrun),
    .clr_overrun(clr_overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push_tile(input logic [DW-1:0] t [0:M-1][0:M-1]);
    for (int o = 0; o < M; o++)
      for (int i = 0; i < M; i++) begin
        beat_t b;
`ifdef DRAIN_COL_MAJOR_EN
        b.row = i; b.col = o;
`else
        b.row = o; b.col = i;
`endif
        b.data = t[b.row][b.col];
        b.last = (b.row == M - 1) && (b.col == M - 1);
        q.push_back(b);
      end
  endtask
  // one clock: apply inputs, predict the edge, then commit the prediction
  task automatic step(input bit d, input bit r, input bit c);
    logic [DW-1:0] snap [0:M-1][0:M-1];
    bit acc, nov;
    int nxt;
    done = d; m_ready = r; clr_overrun = c;
    snap = result_in;
    acc = d && (pending == 0 || (pending == 1 && r));
    nxt = acc ? M * M : (pending > 0 && r) ? pending - 1 : pending;
    nov = (d && !acc) ? 1'b1 : c ? 1'b0 : ov;
    @(posedge clk);
    pending = nxt;
    ov = nov;
    if (acc) push_tile(snap);
    #1;
  endtask
  task automatic rand_tile();
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) result_in[i][j] = $urandom;
  endtask
  always @(negedge clk) begin
    if (reset_n) begin
      chk("m_valid", {31'b0, m_valid}, {31'b0, pending > 0});
      chk("busy", {31'b0, busy}, {31'b0, pending > 0});
      chk("overrun", {31'b0, overrun}, {31'b0, ov});
      if (m_valid && q.size() > 0) begin
        chk("m_data", m_data, q[0].data);
        chk("m_row", DW'(m_row), DW'(q[0].row));
        chk("m_col", DW'(m_col), DW'(q[0].col));
        chk("m_last", {31'b0, m_last}, {31'b0, q[0].last});
        if (m_ready) void'(q.pop_front());
      end else if (!m_valid) begin
        chk("idle_data", m_data, '0);
        chk("idle_rowcol", DW'({m_row, m_col}), '0);
        chk("idle_last", {31'b0, m_last}, '0);
      end
    end
  end
  initial begin
    m_ready = 0; clr_overrun = 0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) result_in[i][j] = '0;
    #3;
    chk("rst_valid", {31'b0, m_valid}, '0);
    chk("rst_busy", {31'b0, busy}, '0);
    chk("rst_overrun", {31'b0, overrun}, '0);
    chk("rst_data", m_data, '0);
    @(posedge clk); #1 reset_n = 1;
    step(0, 1, 0);
    result_in[0][0] = 30;  result_in[0][1] = 36;  result_in[0][2] = 42;
    result_in[1][0] = 66;  result_in[1][1] = 81;  result_in[1][2] = 96;
    result_in[2][0] = 102; result_in[2][1] = 126; result_in[2][2] = 150;
    step(1, 1, 0);
    for (int k = 0; k < 11; k++) step(0, 1, 0);
    step(1, 1, 0);
    for (int k = 0; k < 20; k++) step(0, (k % 3) == 0, 0);
    step(1, 1, 0);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) for (int i = 0; i < M; i++)
        for (int j = 0; j < M; j++) result_in[i][j] = DW'(i * M + j + 1);
      step(k == 7, 1, 0);
    end
    step(0, 1, 0);
    rand_tile();
    step(1, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    for (int k = 0; k < 8; k++) step(0, 1, k == 7);
    for (int n = 0; n < 1500; n++) begin
      bit d;
      rand_tile();
      d = (pending == 1) ? $urandom_range(0, 1) == 1 : $urandom_range(0, 7) == 0;
      step(d, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    rand_tile();
    step(1, 1, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 0);
    step(1, 0, 0);
    reset_n = 0;
    #1;
    chk("mid_rst_valid", {31'b0, m_valid}, '0);
    chk("mid_rst_busy", {31'b0, busy}, '0);
    chk("mid_rst_overrun", {31'b0, overrun}, '0);
    chk("mid_rst_last", {31'b0, m_last}, '0);
    q.delete();
    pending = 0;
    ov = 0;
    @(posedge clk); @(posedge clk); #1 reset_n = 1;
    for (int k = 0; k < 5; k++) step(0, 1, 0);
    rand_tile();
    step(1, 1, 0);
    for (int k = 0; k < 15; k++) step(0, 1, 0);
    chk("queue_drained", DW'(q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
